compound_assign_acc: RTL and testbench

//  Multi-channel accumulator that applies SystemVerilog compound-assignment ops (=, +=, -=, &=, |=, ^=, <<=, >>=, <<<=, >>>=)
//  to per-channel registers, one op per accepted request. Parametrised, stateful successor of the constant-folded

---
 rtl/compound_acc_pkg.sv | 20 ++
 rtl/compound_acc_alu.sv | 54 +++++
 rtl/compound_assign_acc.sv | 109 ++++++++++
 tb/tb_compound_assign_acc.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compound_acc_pkg.sv
// Shared opcode definitions for the compound-assignment accumulator.
package compound_acc_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_SET  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SHL  = 4'h6,
    OP_SHR  = 4'h7,
    OP_ASHL = 4'h8,
    OP_ASHR = 4'h9,
    OP_MUL  = 4'hA
  } acc_op_e;

endpackage

// File: rtl/compound_acc_alu.sv
// Combinational compound-assignment ALU: (acc, operand, op) -> (value, carry, legal).
// Opcode A (*=) is legal only when COMPOUND_ACC_MUL_EN is defined.
module compound_acc_alu
  import compound_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  acc_op_e          op,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             legal
);

  logic [WIDTH:0] wide;
`ifdef COMPOUND_ACC_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = acc * operand;
`endif

  always_comb begin
    value = acc;
    carry = 1'b0;
    legal = 1'b1;
    wide  = '0;
    case (op)
      OP_SET: value = operand;
      OP_ADD: begin
        wide  = {1'b0, acc} + {1'b0, operand};
        value = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_SUB: begin
        // Bit WIDTH of the extended difference is the borrow
        wide  = {1'b0, acc} - {1'b0, operand};
        value = wide[WIDTH-1:0];
        carry = wide[WIDTH];
      end
      OP_AND: value = acc & operand;
      OP_OR:  value = acc | operand;
      OP_XOR: value = acc ^ operand;
      OP_SHL, OP_ASHL: value = acc << operand;
      OP_SHR: value = acc >> operand;
      // Over-wide amounts saturate to sign copies through the signed shift
      OP_ASHR: value = $unsigned($signed(acc) >>> operand);
`ifdef COMPOUND_ACC_MUL_EN
      OP_MUL: value = prod[WIDTH-1:0];
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/compound_assign_acc.sv
// Multi-channel accumulator applying compound-assignment ops with a single output slot.
// Optional *= opcode enabled by COMPOUND_ACC_MUL_EN.
module compound_assign_acc
  import compound_acc_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_chan,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH_W-1:0]  out_chan,
  output logic [WIDTH-1:0] out_value,
  output logic             out_carry,
  output logic             out_err
);

  localparam logic [CH_W:0] CHAN_LIM = (CH_W + 1)'(CHANNELS);

  logic [WIDTH-1:0] acc_q [CHANNELS];
  logic             out_valid_q;
  logic [CH_W-1:0]  out_chan_q;
  logic [WIDTH-1:0] out_value_q;
  logic             out_carry_q;
  logic             out_err_q;

  logic             accept;
  logic             chan_ok;
  logic [WIDTH-1:0] cur_acc;
  logic [WIDTH-1:0] alu_value;
  logic             alu_carry;
  logic             alu_legal;
  logic             do_write;
  logic [WIDTH-1:0] resp_value_d;
  logic             resp_carry_d;
  logic             resp_err_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign chan_ok  = {1'b0, in_chan} < CHAN_LIM;

  // Bounded read so out-of-range channels never index past the array
  always_comb begin
    cur_acc = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_ok && (in_chan == CH_W'(i))) cur_acc = acc_q[i];
    end
  end

  compound_acc_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .acc     (cur_acc),
    .operand (in_operand),
    .op      (acc_op_e'(in_op)),
    .value   (alu_value),
    .carry   (alu_carry),
    .legal   (alu_legal)
  );

  always_comb begin
    do_write     = accept && chan_ok && alu_legal;
    resp_err_d   = !(chan_ok && alu_legal);
    resp_value_d = resp_err_d ? cur_acc : alu_value;
    resp_carry_d = resp_err_d ? 1'b0 : alu_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else if (do_write) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_chan == CH_W'(i)) acc_q[i] <= alu_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_value_q <= '0;
      out_carry_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_chan_q  <= in_chan;
      out_value_q <= resp_value_d;
      out_carry_q <= resp_carry_d;
      out_err_q   <= resp_err_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_value = out_value_q;
  assign out_carry = out_carry_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_compound_assign_acc.sv
// Directed self-checking bench for compound_assign_acc (WIDTH=8, CHANNELS=4).
module tb_compound_assign_acc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_chan;
  logic [3:0] in_op;
  logic [7:0] in_operand;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_chan;
  logic [7:0] out_value;
  logic       out_carry;
  logic       out_err;

  int total;
  int bad;

  compound_assign_acc #(
    .WIDTH    (8),
    .CHANNELS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_chan    (in_chan),
    .in_op      (in_op),
    .in_operand (in_operand),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .out_value  (out_value),
    .out_carry  (out_carry),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request with out_ready high; outputs are sampled 1 time unit after the accept edge.
  task automatic do_op(input logic [1:0] ch, input logic [3:0] op, input logic [7:0] opnd);
    int waited;
    @(negedge clk);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_chan    = ch;
    in_op      = op;
    in_operand = opnd;
    waited     = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid   = 1'b0;
    in_chan    = '0;
    in_op      = '0;
    in_operand = '0;
    out_ready  = 1'b1;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_chan, out_value, out_carry, out_err} !== 13'b0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%0b ch=%0d val=%h c=%0b e=%0b required all 0",
               out_valid, out_chan, out_value, out_carry, out_err);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %0b required 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_raw();
    do_op(2'd0, 4'h1, 8'h05);
    total++;
    if ({out_valid, out_value, out_carry, out_err} !== {1'b1, 8'h05, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_first: got v=%0b val=%h c=%0b e=%0b required 1 05 0 0",
               out_valid, out_value, out_carry, out_err);
    end
    do_op(2'd0, 4'h1, 8'h05);
    total++;
    if ({out_valid, out_chan, out_value, out_carry, out_err} !== {1'b1, 2'd0, 8'h0A, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL add_raw: got v=%0b ch=%0d val=%h c=%0b e=%0b required 1 0 0a 0 0",
               out_valid, out_chan, out_value, out_carry, out_err);
    end
  endtask

  task automatic test_carry_borrow();
    do_op(2'd1, 4'h0, 8'hFF);
    total++;
    if ({out_chan, out_value, out_carry} !== {2'd1, 8'hFF, 1'b0}) begin
      bad++;
      $display("FAIL set_ff: got ch=%0d val=%h c=%0b required 1 ff 0", out_chan, out_value, out_carry);
    end
    do_op(2'd1, 4'h1, 8'h02);
    total++;
    if ({out_value, out_carry} !== {8'h01, 1'b1}) begin
      bad++;
      $display("FAIL add_carry: got val=%h c=%0b required 01 1", out_value, out_carry);
    end
    do_op(2'd1, 4'h2, 8'h03);
    total++;
    if ({out_value, out_carry} !== {8'hFE, 1'b1}) begin
      bad++;
      $display("FAIL sub_borrow: got val=%h c=%0b required fe 1", out_value, out_carry);
    end
    do_op(2'd1, 4'h2, 8'h0E);
    total++;
    if ({out_value, out_carry} !== {8'hF0, 1'b0}) begin
      bad++;
      $display("FAIL sub_noborrow: got val=%h c=%0b required f0 0", out_value, out_carry);
    end
  endtask

  task automatic test_shift_logic();
    logic [3:0] ops  [10] = '{4'h0, 4'h9, 4'h7, 4'h6, 4'h0, 4'h9, 4'h0, 4'h8, 4'h3, 4'h5};
    logic [1:0] chs  [10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    logic [7:0] opnd [10] = '{8'h81, 8'h01, 8'h01, 8'h09, 8'h80, 8'h14, 8'h03, 8'h02, 8'h0A, 8'hFF};
    logic [7:0] exp  [10] = '{8'h81, 8'hC0, 8'h60, 8'h00, 8'h80, 8'hFF, 8'h03, 8'h0C, 8'h08, 8'hF7};
    for (int i = 0; i < 10; i++) begin
      do_op(chs[i], ops[i], opnd[i]);
      total++;
      if ({out_value, out_carry, out_err} !== {exp[i], 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL shift_logic[%0d]: op=%h got val=%h c=%0b e=%0b required %h 0 0",
                 i, ops[i], out_value, out_carry, out_err, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_chan    = 2'd0;
    in_op      = 4'h1;
    in_operand = 8'h01;
    @(posedge clk);
    #1;
    total++;
    if ({out_valid, out_value} !== {1'b1, 8'h0B}) begin
      bad++;
      $display("FAIL stall_first: got v=%0b val=%h required 1 0b", out_valid, out_value);
    end
    in_operand = 8'h10;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({in_ready, out_valid, out_chan, out_value, out_err} !== {1'b0, 1'b1, 2'd0, 8'h0B, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got rdy=%0b v=%0b ch=%0d val=%h e=%0b required 0 1 0 0b 0",
                 i, in_ready, out_valid, out_chan, out_value, out_err);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_value} !== {1'b1, 8'h1B}) begin
      bad++;
      $display("FAIL stall_resume: got v=%0b val=%h required 1 1b", out_valid, out_value);
    end
  endtask

  task automatic test_mul_illegal();
    do_op(2'd0, 4'h0, 8'h03);
    do_op(2'd0, 4'hA, 8'h05);
`ifdef COMPOUND_ACC_MUL_EN
    total++;
    if ({out_value, out_carry, out_err} !== {8'h0F, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mul_op: got val=%h c=%0b e=%0b required 0f 0 0", out_value, out_carry, out_err);
    end
    do_op(2'd0, 4'hF, 8'h01);
    total++;
    if ({out_value, out_carry, out_err} !== {8'h0F, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL illegal_op: got val=%h c=%0b e=%0b required 0f 0 1", out_value, out_carry, out_err);
    end
`else
    total++;
    if ({out_value, out_carry, out_err} !== {8'h03, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mul_disabled: got val=%h c=%0b e=%0b required 03 0 1", out_value, out_carry, out_err);
    end
    do_op(2'd0, 4'hF, 8'h01);
    total++;
    if ({out_value, out_carry, out_err} !== {8'h03, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL illegal_op: got val=%h c=%0b e=%0b required 03 0 1", out_value, out_carry, out_err);
    end
`endif
    // Illegal ops must not have written the accumulator
    do_op(2'd0, 4'h4, 8'h00);
    total++;
`ifdef COMPOUND_ACC_MUL_EN
    if ({out_value, out_err} !== {8'h0F, 1'b0}) begin
      bad++;
      $display("FAIL illegal_nowrite: got val=%h e=%0b required 0f 0", out_value, out_err);
    end
`else
    if ({out_value, out_err} !== {8'h03, 1'b0}) begin
      bad++;
      $display("FAIL illegal_nowrite: got val=%h e=%0b required 03 0", out_value, out_err);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_chan    = 2'd1;
    in_op      = 4'h4;
    in_operand = 8'h55;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_valid: got %0b required 1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_value, in_ready} !== {1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid: got v=%0b val=%h rdy=%0b required 0 00 1", out_valid, out_value, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      do_op(2'(ch), 4'h4, 8'h00);
      total++;
      if ({out_chan, out_value, out_err} !== {2'(ch), 8'h00, 1'b0}) begin
        bad++;
        $display("FAIL post_reset_ch%0d: got ch=%0d val=%h e=%0b required %0d 00 0",
                 ch, out_chan, out_value, out_err, ch);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add_raw();
    test_carry_borrow();
    test_shift_logic();
    test_stall();
    test_mul_illegal();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
